axi_read_arbiter: RTL

- Shares the single AXI read channel between the instruction-cache FSM and the data-cache FSM.
- Today the two read-start strobes are simply ORed together. This block replaces that OR with registered arbitration, an ownership lock for the whole burst, and per-requester routing of read beats and r_last.
- Adds burst-length and timeout checking.
- Sits in control_unit between the cache FSMs and the AXI read master.

---
 rtl/axi_read_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/axi_read_arbiter.sv
// Round-robin arbiter sharing one AXI read channel between the I-cache and D-cache fill FSMs.
// Holds ownership for the whole burst, routes beats to the owner, and flags bad burst length or timeout.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | channel free, arbitrate pending requests
// S_ISSUE | one cycle: start pulse to read master, grant pulse to winner
// S_BURST | beats routed to owner until r_last or timeout
module axi_read_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int BEATS       = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_instr_req,
    input  logic [ADDR_W-1:0] i_instr_addr,
    input  logic              i_data_req,
    input  logic [ADDR_W-1:0] i_data_addr,
    output logic              o_instr_gnt,
    output logic              o_data_gnt,
    output logic              o_start_read,
    output logic [ADDR_W-1:0] o_read_addr,
    input  logic              i_r_valid,
    input  logic              i_r_last,
    output logic              o_instr_r_valid,
    output logic              o_instr_r_last,
    output logic              o_data_r_valid,
    output logic              o_data_r_last,
    output logic              o_busy,
    output logic              o_owner,
    output logic              o_len_err,
    output logic              o_timeout
);

    localparam int BW = $clog2(BEATS);
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BURST} state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_winner_q, last_winner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BW-1:0]     beat_cnt_q, beat_cnt_d;
    logic              beat_over_q, beat_over_d;
    logic [TW-1:0]     tmo_cnt_q, tmo_cnt_d;
    logic              len_err_q, len_err_d;
    logic              timeout_q, timeout_d;

    logic in_burst;
    logic burst_done;
    logic tmo_hit;
    logic pick_data;

    assign in_burst   = (state_q == S_BURST);
    assign burst_done = i_r_valid & i_r_last;
    assign tmo_hit    = in_burst & (tmo_cnt_q == TMO_LAST) & ~burst_done;
    // Ties go to whoever did not win last; a lone requester always wins.
    assign pick_data  = i_data_req & (~i_instr_req | ~last_winner_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            owner_q       <= 1'b0;
            last_winner_q <= 1'b1;
            addr_q        <= '0;
            beat_cnt_q    <= '0;
            beat_over_q   <= 1'b0;
            tmo_cnt_q     <= '0;
            len_err_q     <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            last_winner_q <= last_winner_d;
            addr_q        <= addr_d;
            beat_cnt_q    <= beat_cnt_d;
            beat_over_q   <= beat_over_d;
            tmo_cnt_q     <= tmo_cnt_d;
            len_err_q     <= len_err_d;
            timeout_q     <= timeout_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_winner_d = last_winner_q;
        addr_d        = addr_q;
        beat_cnt_d    = beat_cnt_q;
        beat_over_d   = beat_over_q;
        tmo_cnt_d     = tmo_cnt_q;
        len_err_d     = len_err_q;
        timeout_d     = timeout_q;
        case (state_q)
            S_IDLE: begin
                if (i_instr_req | i_data_req) begin
                    owner_d       = pick_data;
                    last_winner_d = pick_data;
                    addr_d        = pick_data ? i_data_addr : i_instr_addr;
                    state_d       = S_ISSUE;
                end
            end
            S_ISSUE: begin
                beat_cnt_d  = '0;
                beat_over_d = 1'b0;
                tmo_cnt_d   = '0;
                state_d     = S_BURST;
            end
            S_BURST: begin
                tmo_cnt_d = tmo_cnt_q + TW'(1);
                // Counter saturates; a non-last beat at the saturated count marks the burst as overlong.
                if (i_r_valid) begin
                    if (beat_cnt_q != BEAT_LAST) begin
                        beat_cnt_d = beat_cnt_q + BW'(1);
                    end else if (!i_r_last) begin
                        beat_over_d = 1'b1;
                    end
                end
                if (burst_done) begin
                    if ((beat_cnt_q != BEAT_LAST) || beat_over_q) begin
                        len_err_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign o_start_read    = (state_q == S_ISSUE);
    assign o_instr_gnt     = o_start_read & ~owner_q;
    assign o_data_gnt      = o_start_read & owner_q;
    assign o_read_addr     = addr_q;
    assign o_busy          = (state_q != S_IDLE);
    assign o_owner         = owner_q;
    assign o_instr_r_valid = in_burst & ~owner_q & i_r_valid;
    assign o_instr_r_last  = in_burst & ~owner_q & i_r_last & ~tmo_hit;
    assign o_data_r_valid  = in_burst & owner_q & i_r_valid;
    assign o_data_r_last   = in_burst & owner_q & i_r_last & ~tmo_hit;
    assign o_len_err       = len_err_q;
    assign o_timeout       = timeout_q;

endmodule
